// File: rtl/alu_word_seq_if.sv
// Control-side handshake between the MIPS control path and alu_word_seq:
// request/opcode/operands in, busy/done and the held result flags out.
interface alu_word_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         err;

    modport master (output start, op, a, b, input busy, done, result, cout, ovf, err);
    modport slave  (input start, op, a, b, output busy, done, result, cout, ovf, err);
endinterface

// File: rtl/alu_word_seq.sv
// Nibble-serial word ALU sequencer: drives an external 4-bit ALU slice one
// nibble per clock, LSB first, rippling the carry through carry_q.
module alu_word_seq #(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_word_seq_if.slave bus,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic          alu_cin,
    output logic          alu_binv,
    output logic [3:0]    alu_less,
    output logic          alu_sel1,
    output logic          alu_sel0,
    input  logic [3:0]    alu_result,
    input  logic          alu_co
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic             carry_q, cout_q, ovf_q, err_q;

    logic             accept, last;
    logic [IDX_W+1:0] nib_base;
    logic [W-1:0]     sum_full;
    logic             b_msb_eff, ovf_int;

    // DONE is not busy, so a start seen in DONE is accepted with no idle gap.
    assign accept   = bus.start && (state_q != RUN);
    assign last     = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_base = {idx_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_binv = 1'b0;
        alu_sel1 = 1'b0;
        alu_sel0 = 1'b0;
        if (state_q == RUN) begin
            alu_a = a_q[nib_base +: 4];
            alu_b = b_q[nib_base +: 4];
            case (op_q)
                OP_ADD: begin
                    alu_sel1 = 1'b1;
                    alu_cin  = (idx_q == '0) ? 1'b0 : carry_q;
                end
                OP_SUB, OP_SLT: begin
                    alu_sel1 = 1'b1;
                    alu_binv = 1'b1;
                    alu_cin  = (idx_q == '0) ? 1'b1 : carry_q;
                end
                OP_OR:   alu_sel0 = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_less = 4'b0000;

    // Full word as it will look once the current nibble lands.
    always_comb begin
        sum_full                = result_q;
        sum_full[nib_base +: 4] = alu_result;
    end

    assign b_msb_eff = (op_q == OP_ADD) ? b_q[W-1] : ~b_q[W-1];
    assign ovf_int   = (a_q[W-1] == b_msb_eff) && (sum_full[W-1] != a_q[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == RUN) begin
            idx_q   <= idx_q + 1'b1;
            carry_q <= alu_co;
            if (!last) begin
                result_q <= sum_full;
            end else begin
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
                err_q  <= 1'b0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        result_q <= sum_full;
                        cout_q   <= alu_co;
                        ovf_q    <= ovf_int;
                    end
                    OP_SLT:        result_q <= {{(W-1){1'b0}}, sum_full[W-1] ^ ovf_int};
                    OP_AND, OP_OR: result_q <= sum_full;
                    default: begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_word_seq.sv
// Self-checking bench for alu_word_seq: behavioural 4-bit slice model,
// scoreboard of expected word results, scenario tasks run in sequence.
module tb_alu_word_seq;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_a, alu_b, alu_less, alu_result;
    logic       alu_cin, alu_binv, alu_sel1, alu_sel0, alu_co;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    alu_word_seq_if #(.NIBBLES(NIBBLES)) bus();

    alu_word_seq #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_binv   (alu_binv),
        .alu_less   (alu_less),
        .alu_sel1   (alu_sel1),
        .alu_sel0   (alu_sel0),
        .alu_result (alu_result),
        .alu_co     (alu_co)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external 4-bit ALU slice.
    logic [3:0] slice_b;
    logic [4:0] slice_sum;
    always_comb begin
        slice_b   = alu_binv ? ~alu_b : alu_b;
        slice_sum = {1'b0, alu_a} + {1'b0, slice_b} + {4'b0000, alu_cin};
        case ({alu_sel1, alu_sel0})
            2'b00:   alu_result = alu_a & slice_b;
            2'b01:   alu_result = alu_a | slice_b;
            default: alu_result = slice_sum[3:0];
        endcase
        alu_co = slice_sum[4];
    end

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        case (op)
            OP_AND: e.result = a & b;
            OP_OR:  e.result = a | b;
            OP_ADD: begin
                s        = {1'b0, a} + {1'b0, b};
                e.result = s[W-1:0];
                e.cout   = s[W];
                e.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s        = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.result = s[W-1:0];
                e.cout   = s[W];
                e.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            OP_SLT:  e.result = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] r, input logic c, input logic o, input logic e);
        exp_q.push_back(exp_t'{result: r, cout: c, ovf: o, err: e});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, pops the scoreboard and compares; returns at the done negedge.
    task automatic collect(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: done=%b seen with no expected result queued", name, bus.done);
        end else begin
            e = exp_q.pop_front();
            if (bus.done !== 1'b1) begin
                bad++;
                $display("FAIL %s: done never rose within 20 cycles", name);
            end else if (bus.result !== e.result || bus.cout !== e.cout ||
                         bus.ovf !== e.ovf || bus.err !== e.err) begin
                bad++;
                $display("FAIL %s: got result=%h cout=%b ovf=%b err=%b, want result=%h cout=%b ovf=%b err=%b",
                         name, bus.result, bus.cout, bus.ovf, bus.err, e.result, e.cout, e.ovf, e.err);
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b);
        collect(name);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        total++;
        if ({bus.result, bus.cout, bus.ovf, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_flags: result=%h cout=%b ovf=%b err=%b, want all 0",
                     bus.result, bus.cout, bus.ovf, bus.err);
        end
        total++;
        if ({alu_a, alu_b, alu_cin, alu_binv, alu_less, alu_sel1, alu_sel0} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_slice: a=%h b=%h cin=%b binv=%b less=%h sel=%b%b, want all 0",
                     alu_a, alu_b, alu_cin, alu_binv, alu_less, alu_sel1, alu_sel0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_timing;
        push_exp(16'h0100, 1'b0, 1'b0, 1'b0);
        issue(OP_ADD, 16'h00FF, 16'h0001);
        for (int k = 0; k < NIBBLES; k++) begin
            total++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL add_busy_cycle%0d: busy=%b done=%b, want 1 0", k, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL add_done_latency: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end
        collect("add_00ff_0001");
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL add_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_arith;
        push_exp(16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_8000_0001", OP_SUB, 16'h8000, 16'h0001);
        push_exp(16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_0000_0001", OP_SUB, 16'h0000, 16'h0001);
        push_exp(16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("slt_ffff_0001", OP_SLT, 16'hFFFF, 16'h0001);
        push_exp(16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("slt_7fff_8000", OP_SLT, 16'h7FFF, 16'h8000);
        push_exp(16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_7fff_0001", OP_ADD, 16'h7FFF, 16'h0001);
    endtask

    task automatic test_logic_illegal;
        push_exp(16'h3030, 1'b0, 1'b0, 1'b0);
        run_op("and_f0f0_3c3c", OP_AND, 16'hF0F0, 16'h3C3C);
        push_exp(16'hFCFC, 1'b0, 1'b0, 1'b0);
        run_op("or_f0f0_3c3c", OP_OR, 16'hF0F0, 16'h3C3C);
        push_exp(16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("illegal_011", 3'b011, 16'hFFFF, 16'h1234);
    endtask

    task automatic test_slice_drive;
        logic [W-1:0] a, b;
        logic [3:0]   cin_exp;
        a       = 16'h1234;
        b       = 16'h0FFF;
        cin_exp = 4'b1110;
        push_exp(16'h2233, 1'b0, 1'b0, 1'b0);
        issue(OP_ADD, a, b);
        for (int k = 0; k < NIBBLES; k++) begin
            total++;
            if (alu_a !== a[4*k +: 4] || alu_b !== b[4*k +: 4] || alu_cin !== cin_exp[k] ||
                {alu_sel1, alu_sel0, alu_binv} !== 3'b100) begin
                bad++;
                $display("FAIL slice_nibble%0d: a=%h b=%h cin=%b sel/binv=%b%b%b, want a=%h b=%h cin=%b sel/binv=100",
                         k, alu_a, alu_b, alu_cin, alu_sel1, alu_sel0, alu_binv,
                         a[4*k +: 4], b[4*k +: 4], cin_exp[k]);
            end
            @(negedge clk);
        end
        collect("slice_add_1234_0fff");
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        push_exp(16'h0007, 1'b0, 1'b0, 1'b0);
        issue(OP_ADD, 16'h0003, 16'h0004);
        bus.start = 1'b1;
        bus.op    = OP_OR;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        collect("busy_ignore_first");
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL busy_ignore_queued%0d: busy=%b done=%b, want 0 0", k, bus.busy, bus.done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        push_exp(16'h3333, 1'b0, 1'b0, 1'b0);
        push_exp(16'hFFFE, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(negedge clk);
        bus.op    = OP_SUB;
        bus.a     = 16'h0005;
        bus.b     = 16'h0007;
        collect("b2b_first");
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_idle: busy=%b done=%b after DONE with start held, want 1 0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
        collect("b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        issue(OP_ADD, 16'h0F0F, 16'h0101);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.err} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%b done=%b result=%h cout=%b ovf=%b err=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.err);
        end
        total++;
        if ({alu_a, alu_b, alu_cin, alu_binv, alu_sel1, alu_sel0} !== 12'h000) begin
            bad++;
            $display("FAIL abort_slice: a=%h b=%h cin=%b binv=%b sel=%b%b, want all 0",
                     alu_a, alu_b, alu_cin, alu_binv, alu_sel1, alu_sel0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done%0d: done=%b busy=%b, want 0 0", k, bus.done, bus.busy);
            end
        end
        push_exp(16'h1010, 1'b0, 1'b0, 1'b0);
        run_op("after_abort_add", OP_ADD, 16'h0F0F, 16'h0101);
    endtask

    task automatic test_random;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            exp_q.push_back(model(op, a, b));
            run_op($sformatf("rand%0d_op%b", i, op), op, a, b);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_add_timing();
        test_arith();
        test_logic_illegal();
        test_slice_drive();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results still expected, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-cycle sequencer that performs WIDTH-bit ALU operations on the existing 4-bit ALU slice, one nibble per clock, least-significant nibble first. Owns operand/result registers, ripples the carry between passes, and drives the slice's a/b/cin/binv/less/sel inputs. It sits between the MIPS control path (start/op handshake) and a single 4-bit ALU instance, so the datapath carries no wide adder.

## Interface
- NIBBLES, default 4: number of 4-bit passes; word width W = 4*NIBBLES (16 by default). Legal values are 2 to 8.
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes are illegal.
- a, b  in  W  operands, captured at the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result, cout, ovf and err are valid.
- result  out  W  registered result; held until the next accepted start.
- cout, ovf, err  out  1 each  carry-out, signed overflow, illegal-op flag; held like result.
- alu_a, alu_b  out  4  nibble operands to the slice.
- alu_cin, alu_binv  out  1  slice carry-in and b-invert.
- alu_less  out  4  slice less input; tied to 4'b0000.
- alu_sel1, alu_sel0  out  1  slice function select: 00 AND, 01 OR, 10 ADD.
- alu_result  in  4  slice result.
- alu_co  in  1  slice carry-out.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: nibble index idx counts 0..NIBBLES-1.
  - DONE: one cycle.
- Transitions: IDLE -> RUN on start. RUN -> DONE on the edge that captures idx=NIBBLES-1. DONE -> RUN on start, otherwise DONE -> IDLE.
- Accept: on an accepting edge, register a, b and op; set idx=0 and carry_reg=0.
- Slice drive in RUN (combinational from registers):
  - alu_a = a_reg[4*idx+3:4*idx] and alu_b = b_reg[4*idx+3:4*idx].
  - ADD: sel=10, binv=0, cin = (idx==0 ? 0 : carry_reg).
  - SUB and SLT: sel=10, binv=1, cin = (idx==0 ? 1 : carry_reg).
  - AND: sel=00. OR: sel=01. Illegal op: sel=00. In all three, binv=0 and cin=0.
- Slice drive in IDLE and DONE: all alu_* outputs are 0.
- Each RUN edge: result nibble idx <= alu_result, carry_reg <= alu_co, idx <= idx+1.
- Finalisation on the last RUN edge. s = the W-bit sum including the final nibble; b' = b_reg for ADD, ~b_reg for SUB and SLT.
  - ADD/SUB: cout = alu_co; ovf = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]).
  - SLT: result = {W-1 zeros, s[W-1] ^ ovf_internal}; cout=0; ovf=0.
  - AND/OR: cout=0; ovf=0.
  - Illegal op: result=0, err=1, cout=0, ovf=0. err=0 for all legal ops.
- start while busy=1 is ignored; it is not queued.
- Arithmetic is modulo 2^W. cout is the raw carry: for SUB, cout=1 means no borrow.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, idx=0, busy=0, done=0, result=0, cout=0, ovf=0, err=0, all alu_*=0. Reset mid-operation aborts with no done pulse.
- Start accepted at edge E0. busy=1 from E0 to E_NIBBLES. Nibble k is captured at edge E(k+1).
- done=1 for exactly the cycle after E_NIBBLES, with busy=0. Latency from start to done is NIBBLES cycles (4 by default).
- Back-to-back: start high during the DONE cycle is accepted, so the throughput is one op per NIBBLES+1 cycles.
- Outputs are stable from E_NIBBLES until the next accepting edge. result is not cleared on acceptance; it is overwritten nibble by nibble during the next RUN.
- Slice path: from a register through the combinational slice back to a register within one cycle. No multicycle constraint applies.

## Test plan
- ADD 0x00FF + 0x0001 -> result 0x0100, cout=0, ovf=0. done exactly 4 cycles after the accepting edge; busy high for 4 cycles.
- SUB 0x8000 - 0x0001 -> 0x7FFF, cout=1, ovf=1.
- SUB 0x0000 - 0x0001 -> 0xFFFF, cout=0, ovf=0.
- SLT with a=0xFFFF, b=0x0001 -> 0x0001.
- SLT with a=0x7FFF, b=0x8000 -> 0x0000 (overflow-corrected).
- AND 0xF0F0 & 0x3C3C -> 0x3030. OR -> 0xFCFC. Both with cout=0.
- Illegal op 011 -> result 0x0000, err=1.
- Slice-drive check on every RUN cycle of ADD 0x1234 + 0x0FFF: alu_a/alu_b equal the expected nibbles and alu_cin equals the previous alu_co.
- start pulsed during busy with different operands -> ignored; the first op's result is unchanged.
- start held through DONE -> second op accepted with no idle cycle.
- rst_n low in the 2nd RUN cycle -> all outputs 0 immediately; no done pulse. A later start runs normally.
